spi_master_ctrl: RTL and testbench

SPI master that turns single-byte host commands into the two-frame serial transactions the SPI_Wrapper slave (SPI slave + 256×8 single-port RAM) expects on SS_n/MOSI/MISO. A write command becomes a write-address frame followed by a write-data frame. A read command becomes a read-address frame followed by a read-data frame, from which the master captures the 8-bit MISO response. It sits directly upstream of SPI_Wrapper and shares its clock.

---
 rtl/spi_master_pkg.sv | 33 +++
 rtl/spi_frame_engine.sv | 138 +++++++++++++
 rtl/spi_master_ctrl.sv | 103 ++++++++++
 tb/tb_spi_master_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared state encodings and frame constants for the SPI master.
// Revision 1.0
`default_nettype none

package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEL     = 3'd1,
    SHIFT   = 3'd2,
    TURN    = 3'd3,
    CAPTURE = 3'd4,
    GAP     = 3'd5
  } frame_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_LAUNCH = 2'd1,
    SEQ_FRAME1 = 2'd2,
    SEQ_FRAME2 = 2'd3
  } seq_state_t;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam int SHIFT_BITS   = 10;
  localparam int CAPTURE_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/spi_frame_engine.sv
// spi_frame_engine: runs one SS_n-low frame (SEL/SHIFT/TURN/CAPTURE) plus its trailing gap.
// Revision 1.0
`default_nettype none

module spi_frame_engine
  import spi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MISO_SKIP  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [ADDR_WIDTH-1:0] payload,
  input  logic                  miso,
  output logic                  ss_n,
  output logic                  mosi,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cap_data
);

  localparam int         FRAME_W    = ADDR_WIDTH + 2;
  localparam logic [3:0] SHIFT_LOAD = 4'(SHIFT_BITS);
  localparam logic [3:0] TURN_LOAD  = 4'((MISO_SKIP > 0) ? MISO_SKIP - 1 : 0);
  localparam logic [3:0] CAP_LOAD   = 4'(CAPTURE_BITS - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  frame_state_t          state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [FRAME_W:0]      sreg, sreg_d;
  logic                  is_rd, is_rd_d;
  logic                  ss_n_d, mosi_d, load;
  logic [ADDR_WIDTH-1:0] cap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sreg     <= '0;
      is_rd    <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      cap_data <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sreg     <= sreg_d;
      is_rd    <= is_rd_d;
      ss_n     <= ss_n_d;
      mosi     <= mosi_d;
      cap_data <= cap_d;
    end
  end

  // SS_n/MOSI are computed for the state being entered, so the pins line up with it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    is_rd_d = is_rd;
    ss_n_d  = 1'b1;
    mosi_d  = 1'b0;
    cap_d   = cap_data;
    done    = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: load = start;
      SEL: begin
        state_d = SHIFT;
        cnt_d   = SHIFT_LOAD;
        ss_n_d  = 1'b0;
        mosi_d  = sreg[FRAME_W];
        sreg_d  = {sreg[FRAME_W-1:0], 1'b0};
      end
      SHIFT: begin
        ss_n_d = 1'b0;
        if (cnt != 4'd0) begin
          cnt_d  = cnt - 4'd1;
          mosi_d = sreg[FRAME_W];
          sreg_d = {sreg[FRAME_W-1:0], 1'b0};
        end else if (!is_rd) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          ss_n_d  = 1'b1;
        end else if (MISO_SKIP != 0) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          state_d = CAPTURE;
          cnt_d   = CAP_LOAD;
        end
      end
      TURN: begin
        ss_n_d = 1'b0;
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          state_d = CAPTURE;
          cnt_d   = CAP_LOAD;
        end
      end
      CAPTURE: begin
        ss_n_d = 1'b0;
        cap_d  = {cap_data[ADDR_WIDTH-2:0], miso};
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          ss_n_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
          load    = start;
        end
      end
      default: state_d = IDLE;
    endcase
    // The path-select bit is sent twice: once ahead of the frame, once as its MSB.
    if (load) begin
      state_d = SEL;
      sreg_d  = {cmd[1], cmd, payload};
      is_rd_d = (cmd == RD_DATA);
      ss_n_d  = 1'b0;
      mosi_d  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host command handshake; sequences address+data frames per command.
// Revision 1.0
`default_nettype none

module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MISO_SKIP  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  seq_state_t            seq, seq_d;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_wdata;
  logic                  start, done;
  logic [1:0]            frame_cmd;
  logic [ADDR_WIDTH-1:0] frame_payload, cap_data;

  assign cmd_ready = (seq == SEQ_IDLE);
  assign busy      = !cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= SEQ_IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      seq       <= seq_d;
      rsp_valid <= (seq == SEQ_FRAME2) && done;
      if (cmd_valid && cmd_ready) begin
        lat_write <= cmd_write;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
      if ((seq == SEQ_FRAME2) && done && !lat_write) begin
        rsp_rdata <= cap_data;
      end
    end
  end

  // The second frame is launched from the first frame's final gap cycle, so no dead cycle.
  always_comb begin
    seq_d         = seq;
    start         = 1'b0;
    frame_cmd     = lat_write ? WR_ADDR : RD_ADDR;
    frame_payload = lat_addr;
    case (seq)
      SEQ_IDLE:   if (cmd_valid) seq_d = SEQ_LAUNCH;
      SEQ_LAUNCH: begin
        start = 1'b1;
        seq_d = SEQ_FRAME1;
      end
      SEQ_FRAME1: begin
        if (done) begin
          start         = 1'b1;
          seq_d         = SEQ_FRAME2;
          frame_cmd     = lat_write ? WR_DATA : RD_DATA;
          frame_payload = lat_write ? lat_wdata : '0;
        end
      end
      SEQ_FRAME2: if (done) seq_d = SEQ_IDLE;
      default:    seq_d = SEQ_IDLE;
    endcase
  end

  spi_frame_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MISO_SKIP (MISO_SKIP),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (frame_cmd),
    .payload (frame_payload),
    .miso    (MISO),
    .ss_n    (SS_n),
    .mosi    (MOSI),
    .done    (done),
    .cap_data(cap_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: random command stream, RAM-slave model on the pins, scoreboarded frames and responses.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_ctrl;

  localparam int AW     = 8;
  localparam int SKIP   = 1;
  localparam int GAP    = 1;
  localparam int LAT_WR = 2 * (12 + GAP) + 1;
  localparam int LAT_RD = 2 * (12 + GAP) + SKIP + 8 + 1;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [AW-1:0] cmd_wdata = '0;
  logic          MISO      = 1'b0;
  logic          cmd_ready, rsp_valid, busy, SS_n, MOSI;
  logic [AW-1:0] rsp_rdata;

  spi_master_ctrl #(.ADDR_WIDTH(AW), .MISO_SKIP(SKIP), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [9:0] frame; logic rd;} exp_frame_t;
  typedef struct {int lat; logic [7:0] rdata; int acc;} exp_rsp_t;

  exp_frame_t fq[$];
  exp_rsp_t   rq[$];
  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];
  logic [7:0] last_rd = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a write is two frames and updates memory; a read returns the memory byte.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data, input bit hold);
    exp_rsp_t r;
    int       n;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    if (wr) begin
      fq.push_back('{frame: {2'b00, addr}, rd: 1'b0});
      fq.push_back('{frame: {2'b01, data}, rd: 1'b0});
      ref_mem[addr] = data;
    end else begin
      fq.push_back('{frame: {2'b10, addr}, rd: 1'b0});
      fq.push_back('{frame: {2'b11, 8'h00}, rd: 1'b1});
      last_rd = ref_mem[addr];
    end
    r.lat   = wr ? LAT_WR : LAT_RD;
    r.rdata = last_rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) check("accept_timeout", 32'(n), 32'd0);
    r.acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    rq.push_back(r);
  endtask

  // Slave stand-in on the pins plus frame scoreboard.
  initial begin : frame_mon
    int         fcyc;
    logic       obs[$];
    logic [7:0] wr_addr, rd_addr, sb, pay;
    logic [31:0] got_bits, exp_bits;
    int         exp_len;
    exp_frame_t e;
    fcyc = 0;
    wr_addr = 8'h00;
    rd_addr = 8'h00;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 37 + 11);
    forever begin
      @(negedge clk);
      if (rst) begin
        fcyc = 0;
        obs.delete();
        fq.delete();
        continue;
      end
      if (!SS_n) begin
        fcyc++;
        obs.push_back(MOSI);
        sb = slave_mem[rd_addr];
        if (fcyc >= 13 + SKIP && fcyc <= 20 + SKIP && obs[2] && obs[3])
          MISO = sb[3'(7 - (fcyc - 13 - SKIP))];
        else
          MISO = 1'($urandom);
      end else begin
        MISO = 1'($urandom);
        check("mosi_idle", 32'(MOSI), 32'd0);
        if (fcyc > 0) begin
          got_bits = '0;
          foreach (obs[i]) got_bits = {got_bits[30:0], obs[i]};
          if (fq.size() == 0) begin
            check("frame_unexpected", 32'(fcyc), 32'd0);
          end else begin
            e = fq.pop_front();
            exp_bits = {30'd0, 1'b0, e.frame[9]};
            for (int i = 9; i >= 0; i--) exp_bits = {exp_bits[30:0], e.frame[i]};
            exp_len  = e.rd ? 12 + SKIP + 8 : 12;
            exp_bits = exp_bits << (exp_len - 12);
            check("frame_len", 32'(obs.size()), 32'(exp_len));
            check("frame_bits", got_bits, exp_bits);
          end
          if (obs.size() >= 12) begin
            for (int i = 0; i < 8; i++) pay[7-i] = obs[4+i];
            case ({obs[2], obs[3]})
              2'b00:   wr_addr = pay;
              2'b01:   slave_mem[wr_addr] = pay;
              2'b10:   rd_addr = pay;
              default: ;
            endcase
          end
          fcyc = 0;
          obs.delete();
        end
      end
    end
  end

  initial begin : rsp_mon
    exp_rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rq.delete();
        continue;
      end
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = rq.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
          check("rsp_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] a, d, old;
    int         n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);

    repeat (2) @(negedge clk);
    check("reset_ss_n", 32'(SS_n), 32'd1);
    check("reset_mosi", 32'(MOSI), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1'b1, 8'hA5, 8'h3C, 1'b0);
    issue(1'b0, 8'hA5, 8'h00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      issue(1'b1, a, d, 1'b1);
      issue(1'b0, a, 8'h00, 1'b1);
    end
    cmd_valid = 1'b0;

    // New fields presented mid-transaction must not disturb it.
    a = 8'($urandom);
    d = 8'($urandom);
    issue(1'b1, a, d, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
    @(negedge clk);
    check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    check("busy_flag", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    issue(1'b0, a, 8'h00, 1'b0);

    // Abort a write at cycle 7 of its data frame.
    old = ref_mem[8'hA5];
    issue(1'b1, 8'hA5, ~old, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_mosi", 32'(MOSI), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    ref_mem[8'hA5] = old;
    last_rd = 8'h00;
    issue(1'b0, 8'hA5, 8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      issue(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
    end
    cmd_valid = 1'b0;

    n = 0;
    while ((rq.size() != 0 || fq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp", 32'(rq.size()), 32'd0);
    check("drain_frames", 32'(fq.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
